dffr_pipe: RTL and testbench

//  Parametrised N-stage resettable register pipeline with valid/ready flow control per stage.

---
 rtl/dffr_pipe.sv | 102 ++++++++++
 tb/tb_dffr_pipe.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/dffr_pipe.sv
// dffr_pipe: Depth-stage resettable register pipeline with per-stage valid/ready,
// bubble collapsing, synchronous flush and a registered occupancy count.
// Optional DFFR_PIPE_XCHECK_EN adds a simulation-only X/Z checker (skipped under SYNTHESIS).
module dffr_pipe #(
    parameter int Width = 8,
    parameter int Depth = 2
) (
    input  logic                       CLK,
    input  logic                       RSTN,
    input  logic [Width-1:0]           DRST,
    input  logic                       FLUSH,
    input  logic                       IN_VALID,
    output logic                       IN_READY,
    input  logic [Width-1:0]           IN_DATA,
    output logic                       OUT_VALID,
    input  logic                       OUT_READY,
    output logic [Width-1:0]           OUT_DATA,
    output logic [$clog2(Depth+1)-1:0] OCC
);

    localparam int OccW = $clog2(Depth + 1);

    generate
        if (Depth < 1) begin : g_bad_depth
            $error("dffr_pipe: Depth must be >= 1");
        end
    endgenerate

    logic [Depth:0]                  rdy;
    logic [Depth-1:0]                src_v;
    logic [Depth-1:0][Width-1:0]     src_d;
    logic [Depth-1:0]                v_q, v_d;
    logic [Depth-1:0][Width-1:0]     d_q, d_d;
    logic [OccW-1:0]                 occ_q, occ_d;

    // Ready ripples back from the output; an empty stage is always ready so bubbles collapse.
    always_comb begin
        rdy        = '0;
        rdy[Depth] = OUT_READY;
        for (int i = Depth - 1; i >= 0; i--) begin
            rdy[i] = ~v_q[i] | rdy[i+1];
        end
    end

    // Next state: flush clears valids, ready stages take their source, data loads only on valid source.
    always_comb begin
        src_v    = '0;
        src_d    = '0;
        v_d      = v_q;
        d_d      = d_q;
        occ_d    = '0;
        src_v[0] = IN_VALID;
        src_d[0] = IN_DATA;
        for (int i = 1; i < Depth; i++) begin
            src_v[i] = v_q[i-1];
            src_d[i] = d_q[i-1];
        end
        for (int i = 0; i < Depth; i++) begin
            v_d[i] = FLUSH ? 1'b0 : rdy[i] ? src_v[i] : v_q[i];
            d_d[i] = (~FLUSH & rdy[i] & src_v[i]) ? src_d[i] : d_q[i];
            occ_d  = occ_d + OccW'(v_d[i]);
        end
    end

    // Stage registers; reset loads DRST into every data stage and empties the pipe.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            v_q   <= '0;
            d_q   <= {Depth{DRST}};
            occ_q <= '0;
        end else begin
            v_q   <= v_d;
            d_q   <= d_d;
            occ_q <= occ_d;
        end
    end

    assign IN_READY  = rdy[0] & ~FLUSH;
    assign OUT_VALID = v_q[Depth-1];
    assign OUT_DATA  = d_q[Depth-1];
    assign OCC       = occ_q;

`ifdef DFFR_PIPE_XCHECK_EN
`ifndef SYNTHESIS
    // Flag unknown controls, unknown accepted input data and unknown data in valid stages.
    always @(posedge CLK) begin
        if (RSTN) begin
            if ($isunknown({IN_VALID, OUT_READY, FLUSH}))
                $error("dffr_pipe: X/Z on IN_VALID/OUT_READY/FLUSH");
            if (IN_VALID && IN_READY && $isunknown(IN_DATA))
                $error("dffr_pipe: X/Z on IN_DATA while accepted");
            for (int i = 0; i < Depth; i++) begin
                if (v_q[i] && $isunknown(d_q[i]))
                    $error("dffr_pipe: X/Z in valid stage %0d", i);
            end
        end
    end
`endif
`else
`endif

endmodule

// File: tb/tb_dffr_pipe.sv
// tb_dffr_pipe: directed checks of dffr_pipe (Depth=3 main instance, Depth=1 for async reset).
module tb_dffr_pipe;

    logic       clk = 1'b0;
    logic       rstn, rstn1;
    logic [7:0] drst, in_data;
    logic       flush, in_valid, out_ready;
    logic       in_ready, out_valid, in_ready1, out_valid1;
    logic [7:0] out_data, out_data1;
    logic [1:0] occ;
    logic [0:0] occ1;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    dffr_pipe #(.Width(8), .Depth(3)) u_dut (
        .CLK(clk), .RSTN(rstn), .DRST(drst), .FLUSH(flush),
        .IN_VALID(in_valid), .IN_READY(in_ready), .IN_DATA(in_data),
        .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_DATA(out_data), .OCC(occ)
    );

    dffr_pipe #(.Width(8), .Depth(1)) u_dut1 (
        .CLK(clk), .RSTN(rstn1), .DRST(drst), .FLUSH(flush),
        .IN_VALID(in_valid), .IN_READY(in_ready1), .IN_DATA(in_data),
        .OUT_VALID(out_valid1), .OUT_READY(out_ready), .OUT_DATA(out_data1), .OCC(occ1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b0; rstn1 = 1'b0; drst = 8'hA5; flush = 1'b0;
        in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        tick(); tick();
        chk("rst_data", 32'(out_data), 32'hA5);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_occ", 32'(occ), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        rstn = 1'b1; rstn1 = 1'b1;
        tick();
        chk("idle_valid", 32'(out_valid), 32'd0);

        // stream 01..10 with OUT_READY held high
        out_ready = 1'b1;
        for (int t = 1; t <= 19; t++) begin
            in_valid = (t <= 16);
            in_data  = 8'(t);
            chk("str_inrdy", 32'(in_ready), 32'd1);
            tick();
            chk("str_valid", 32'(out_valid), 32'((t >= 3) && (t <= 18)));
            if (t >= 3 && t <= 18) chk("str_data", 32'(out_data), 32'(t - 2));
            chk("str_occ", 32'(occ), (t <= 16) ? ((t < 3) ? 32'(t) : 32'd3) : 32'(19 - t));
        end

        // back-pressure
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_data = 8'h21 + 8'(k);
            chk("bp_inrdy", 32'(in_ready), 32'd1);
            tick();
        end
        in_data = 8'h24;
        chk("bp_full_rdy", 32'(in_ready), 32'd0);
        chk("bp_occ", 32'(occ), 32'd3);
        tick();
        chk("bp_hold_rdy", 32'(in_ready), 32'd0);
        chk("bp_hold_data", 32'(out_data), 32'h21);
        chk("bp_hold_valid", 32'(out_valid), 32'd1);
        chk("bp_hold_occ", 32'(occ), 32'd3);
        out_ready = 1'b1;
        #1;
        chk("bp_rel_rdy", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_out2", 32'(out_data), 32'h22);
        chk("bp_occ_rel", 32'(occ), 32'd3);
        tick();
        chk("bp_out3", 32'(out_data), 32'h23);
        tick();
        chk("bp_out4", 32'(out_data), 32'h24);
        chk("bp_out4_v", 32'(out_valid), 32'd1);
        tick();
        chk("bp_empty", 32'(out_valid), 32'd0);

        // bubble collapse with the output stalled
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h3A;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        chk("bub_a_out", 32'(out_data), 32'h3A);
        in_valid = 1'b1; in_data = 8'h3B;
        tick();
        in_valid = 1'b0;
        chk("bub_occ", 32'(occ), 32'd2);
        tick();
        chk("bub_occ2", 32'(occ), 32'd2);
        chk("bub_inrdy", 32'(in_ready), 32'd1);
        chk("bub_a_hold", 32'(out_data), 32'h3A);
        out_ready = 1'b1;
        tick();
        chk("bub_b_out", 32'(out_data), 32'h3B);
        chk("bub_b_valid", 32'(out_valid), 32'd1);
        tick();
        chk("bub_empty", 32'(out_valid), 32'd0);

        // flush a full pipe while offering a word
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_data = 8'h51 + 8'(k);
            tick();
        end
        chk("fl_occ_full", 32'(occ), 32'd3);
        flush = 1'b1; in_data = 8'h54;
        #1;
        chk("fl_inrdy", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_occ", 32'(occ), 32'd0);
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_data_hold", 32'(out_data), 32'h51);
        out_ready = 1'b1;
        tick(); tick(); tick();
        chk("fl_dropped", 32'(out_valid), 32'd0);
        chk("fl_occ_after", 32'(occ), 32'd0);

        // async reset of the single-stage pipe between edges
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h66;
        tick();
        in_valid = 1'b0;
        chk("ar_valid_pre", 32'(out_valid1), 32'd1);
        chk("ar_data_pre", 32'(out_data1), 32'h66);
        chk("ar_occ_pre", 32'(occ1), 32'd1);
        #2;
        drst = 8'h3C;
        rstn1 = 1'b0;
        #1;
        chk("ar_valid", 32'(out_valid1), 32'd0);
        chk("ar_data", 32'(out_data1), 32'h3C);
        chk("ar_occ", 32'(occ1), 32'd0);
        chk("ar_inrdy", 32'(in_ready1), 32'd1);
        tick();
        rstn1 = 1'b1;
        tick();
        chk("ar_after", 32'(out_valid1), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
